// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong ball datapath.
package pong_pkg;

   // Ball controller states.
   typedef enum logic [1:0] {
      SERVE  = 2'd0,
      MOVE   = 2'd1,
      SCORED = 2'd2
   } state_t;

   // Per-frame velocity in pixels, two's complement.
   typedef logic signed [2:0] vel_t;

   // Working width for position arithmetic and comparisons. It has enough
   // headroom for a 10-bit position plus ball or paddle extents.
   typedef logic signed [11:0] coord_t;

   // Default screen and paddle geometry.
   localparam int DEF_H_RES      = 640;
   localparam int DEF_V_RES      = 480;
   localparam int DEF_BALL_SIZE  = 8;
   localparam int DEF_PADDLE_H   = 64;
   localparam int DEF_PADDLE_W   = 8;
   localparam int DEF_PADDLE_L_X = 16;
   localparam int DEF_PADDLE_R_X = 616;
   localparam int DEF_SERVE_WAIT = 60;

   // The most negative code has no positive counterpart.
   localparam vel_t VEL_MOST_NEG = 3'b100;

   // Maps a raw serve vector onto a usable velocity.
   // -4 is clamped to -3 so that a later bounce can negate it.
   // When no_zero is set, 0 becomes +1 so the ball always travels horizontally.
   function automatic vel_t load_vel(input vel_t raw, input logic no_zero);
      vel_t v;
      v = raw;
      if (raw == VEL_MOST_NEG)
         v = vel_t'(-3);
      else if (no_zero && (raw == vel_t'(0)))
         v = vel_t'(1);
      return v;
   endfunction

endpackage

// File: rtl/ball_motion_serve_timer.sv
// Serve delay counter: counts frame ticks and pulses done on the WAIT-th one.
module serve_timer #(
   parameter int WAIT = 60,
   localparam int CW  = (WAIT > 1) ? $clog2(WAIT) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic done
);

   localparam logic [CW-1:0] LAST = CW'(WAIT - 1);

   logic [CW-1:0] count;

   // done marks the tick that completes the wait. The counter wraps to zero on that same edge.
   assign done = tick && !clear && (count == LAST);

   // Tick counter. It is held at zero whenever the owner is not serving.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment.
      // This lets every flop sample the pre-edge values, regardless of the order of the statements.
      if (rst || clear || done)
         count <= '0;
      else if (tick)
         count <= count + CW'(1);
   end

endmodule

// File: rtl/ball_motion.sv
// Ball motion controller.
// Serves from screen centre, moves once per frame, bounces off the walls
// and the paddles, and reports points when the ball leaves past a paddle.
module ball_motion
   import pong_pkg::*;
#(
   parameter int H_RES      = DEF_H_RES,
   parameter int V_RES      = DEF_V_RES,
   parameter int BALL_SIZE  = DEF_BALL_SIZE,
   parameter int PADDLE_H   = DEF_PADDLE_H,
   parameter int PADDLE_W   = DEF_PADDLE_W,
   parameter int PADDLE_L_X = DEF_PADDLE_L_X,
   parameter int PADDLE_R_X = DEF_PADDLE_R_X,
   parameter int SERVE_WAIT = DEF_SERVE_WAIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [2:0] x_vect_in,
   input  logic [2:0] y_vect_in,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       score_l,
   output logic       score_r,
   output logic       serving
);

   // Serve position: the ball is centred on the screen.
   localparam logic [9:0] CX = 10'(H_RES / 2 - BALL_SIZE / 2);
   localparam logic [9:0] CY = 10'(V_RES / 2 - BALL_SIZE / 2);

   // Geometry used in comparisons, at the signed working width.
   localparam coord_t BSZ    = coord_t'(BALL_SIZE);
   localparam coord_t PAD_H  = coord_t'(PADDLE_H);
   localparam coord_t L_FACE = coord_t'(PADDLE_L_X + PADDLE_W);
   localparam coord_t R_FACE = coord_t'(PADDLE_R_X);
   localparam coord_t X_MAX  = coord_t'(H_RES - BALL_SIZE);
   localparam coord_t Y_MAX  = coord_t'(V_RES - BALL_SIZE);

   // Positions the ball snaps to after a bounce.
   localparam logic [9:0] X_L_STOP = 10'(PADDLE_L_X + PADDLE_W);
   localparam logic [9:0] X_R_STOP = 10'(PADDLE_R_X - BALL_SIZE);
   localparam logic [9:0] Y_BOT    = 10'(V_RES - BALL_SIZE);

   state_t     state_q, state_d;
   logic [9:0] ball_x_q, ball_x_d;
   logic [9:0] ball_y_q, ball_y_d;
   vel_t       vx_q, vx_d;
   vel_t       vy_q, vy_d;
   logic       score_l_q, score_l_d;
   logic       score_r_q, score_r_d;

   logic timer_clear;
   logic timer_done;

   // The serve counter only runs in SERVE. Any other state keeps it cleared,
   // so ticks seen in SCORED cannot shorten the next serve.
   assign timer_clear = (state_q != SERVE);

   serve_timer #(
      .WAIT (SERVE_WAIT)
   ) u_serve_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (timer_clear),
      .tick  (frame_tick),
      .done  (timer_done)
   );

   // Candidate next position: 11-bit signed sum with the velocity sign-extended.
   logic signed [10:0] vx_ext, vy_ext;
   logic signed [10:0] nx, ny;

   assign vx_ext = {{8{vx_q[2]}}, vx_q};
   assign vy_ext = {{8{vy_q[2]}}, vy_q};
   assign nx     = $signed({1'b0, ball_x_q}) + vx_ext;
   assign ny     = $signed({1'b0, ball_y_q}) + vy_ext;

   // Widened copies so the comparisons below are all signed and width-matched.
   coord_t nx_w, ny_w, bx_w, by_w, pl_w, pr_w;

   assign nx_w = {nx[10], nx};
   assign ny_w = {ny[10], ny};
   assign bx_w = {2'b00, ball_x_q};
   assign by_w = {2'b00, ball_y_q};
   assign pl_w = {2'b00, paddle_l_y};
   assign pr_w = {2'b00, paddle_r_y};

   logic overlap_l, overlap_r;
   logic hit_l, hit_r;
   logic miss_l, miss_r;

   // Vertical overlap with each paddle, using the ball position before the move.
   assign overlap_l = (by_w + BSZ > pl_w) && (by_w < pl_w + PAD_H);
   assign overlap_r = (by_w + BSZ > pr_w) && (by_w < pr_w + PAD_H);

   // A paddle hit requires two things.
   // The ball must reach or cross the paddle face during this move.
   // The ball must have started on the playfield side of that face.
   assign hit_l = vx_q[2] && (nx_w <= L_FACE) && (bx_w >= L_FACE) && overlap_l;
   assign hit_r = !vx_q[2] && (vx_q != vel_t'(0)) &&
                  (nx_w + BSZ >= R_FACE) && (bx_w + BSZ <= R_FACE) && overlap_r;

   // A ball that leaves on the left scores for the right player, and vice versa.
   assign miss_r = nx[10];
   assign miss_l = (nx_w > X_MAX);

   // Next-state and next-datapath logic for the controller.
   always_comb begin
      // NOTE: every always_comb output is given a default first.
      // A path that forgets to assign an output would otherwise infer a latch.
      state_d   = state_q;
      ball_x_d  = ball_x_q;
      ball_y_d  = ball_y_q;
      vx_d      = vx_q;
      vy_d      = vy_q;
      score_l_d = 1'b0;
      score_r_d = 1'b0;

      unique case (state_q)
         SERVE: begin
            ball_x_d = CX;
            ball_y_d = CY;
            if (timer_done) begin
               vx_d    = load_vel(vel_t'(x_vect_in), 1'b1);
               vy_d    = load_vel(vel_t'(y_vect_in), 1'b0);
               state_d = MOVE;
            end
         end

         MOVE: begin
            if (frame_tick) begin
               if (!hit_l && !hit_r && (miss_l || miss_r)) begin
                  // A point freezes the ball where it is and suppresses any wall bounce.
                  score_r_d = miss_r;
                  score_l_d = miss_l;
                  state_d   = SCORED;
               end else begin
                  // Horizontal: a paddle bounce or a plain move.
                  if (hit_l) begin
                     ball_x_d = X_L_STOP;
                     vx_d     = -vx_q;
                  end else if (hit_r) begin
                     ball_x_d = X_R_STOP;
                     vx_d     = -vx_q;
                  end else begin
                     ball_x_d = nx[9:0];
                  end

                  // Vertical: this is independent of the horizontal result,
                  // so a corner hit bounces on both axes.
                  if (ny[10]) begin
                     ball_y_d = '0;
                     vy_d     = -vy_q;
                  end else if (ny_w > Y_MAX) begin
                     ball_y_d = Y_BOT;
                     vy_d     = -vy_q;
                  end else begin
                     ball_y_d = ny[9:0];
                  end
               end
            end
         end

         SCORED: begin
            // This state lasts one cycle and ignores frame_tick. The ball returns to centre.
            state_d  = SERVE;
            ball_x_d = CX;
            ball_y_d = CY;
            vx_d     = vel_t'(0);
            vy_d     = vel_t'(0);
         end

         default: begin
            state_d  = SERVE;
            ball_x_d = CX;
            ball_y_d = CY;
            vx_d     = vel_t'(0);
            vy_d     = vel_t'(0);
         end
      endcase
   end

   // State and datapath registers.
   // A synchronous reset drops any ball in flight without awarding a point.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SERVE;
         ball_x_q  <= CX;
         ball_y_q  <= CY;
         vx_q      <= vel_t'(0);
         vy_q      <= vel_t'(0);
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ball_x_q  <= ball_x_d;
         ball_y_q  <= ball_y_d;
         vx_q      <= vx_d;
         vy_q      <= vy_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
      end
   end

   assign ball_x  = ball_x_q;
   assign ball_y  = ball_y_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign serving = (state_q == SERVE);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion with a two-tick serve delay.
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic [2:0] x_vect_in = 3'b000;
   logic [2:0] y_vect_in = 3'b000;
   logic [9:0] paddle_l_y = '0;
   logic [9:0] paddle_r_y = '0;
   logic [9:0] ball_x, ball_y;
   logic       score_l, score_r, serving;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ball_motion #(
      .SERVE_WAIT (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .x_vect_in  (x_vect_in),
      .y_vect_in  (y_vect_in),
      .paddle_l_y (paddle_l_y),
      .paddle_r_y (paddle_r_y),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .score_l    (score_l),
      .score_r    (score_r),
      .serving    (serving)
   );

   typedef struct {
      bit         do_rst;
      int         n_ticks;
      logic [2:0] xv;
      logic [2:0] yv;
      logic [9:0] pl;
      logic [9:0] pr;
      int         ex;
      int         ey;
      bit         es;
      bit         esl;
      bit         esr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_outputs(input string tag, input int ex, input int ey,
                                input bit es, input bit esl, input bit esr);
      check({tag, ".ball_x"},  32'(ball_x),  32'(ex));
      check({tag, ".ball_y"},  32'(ball_y),  32'(ey));
      check({tag, ".serving"}, 32'(serving), 32'(es));
      check({tag, ".score_l"}, 32'(score_l), 32'(esl));
      check({tag, ".score_r"}, 32'(score_r), 32'(esr));
   endtask

   // One frame: tick high for one cycle, then return at the following falling edge.
   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic add_vec(input bit r, input int n, input logic [2:0] xv, input logic [2:0] yv,
                          input logic [9:0] pl, input logic [9:0] pr, input int ex, input int ey,
                          input bit es, input bit esl, input bit esr);
      vec_t v;
      v.do_rst = r;  v.n_ticks = n;  v.xv = xv;  v.yv = yv;
      v.pl = pl;     v.pr = pr;      v.ex = ex;  v.ey = ey;
      v.es = es;     v.esl = esl;    v.esr = esr;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Rally: serve (+2,-2), top bounce, right paddle hit, bottom bounce, left paddle hit.
      add_vec(1,   0, 3'b010, 3'b110, 10'd280, 10'd0, 316, 236, 1, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 316, 236, 1, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 316, 236, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 318, 234, 0, 0, 0);
      add_vec(0, 116, 3'b010, 3'b110, 10'd280, 10'd0, 550,   2, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 552,   0, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 554,   0, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 556,   2, 0, 0, 0);
      add_vec(0,  25, 3'b010, 3'b110, 10'd280, 10'd0, 606,  52, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 608,  54, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 606,  56, 0, 0, 0);
      add_vec(0, 208, 3'b010, 3'b110, 10'd280, 10'd0, 190, 472, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 188, 472, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0, 186, 470, 0, 0, 0);
      add_vec(0,  80, 3'b010, 3'b110, 10'd280, 10'd0,  26, 310, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0,  24, 308, 0, 0, 0);
      add_vec(0,   1, 3'b010, 3'b110, 10'd280, 10'd0,  26, 306, 0, 0, 0);
      // Right-side miss: serve (+3,0), the ball passes the right paddle and scores for the left player.
      add_vec(1,   0, 3'b011, 3'b000, 10'd0,   10'd0, 316, 236, 1, 0, 0);
      add_vec(0,   2, 3'b011, 3'b000, 10'd0,   10'd0, 316, 236, 0, 0, 0);
      add_vec(0, 105, 3'b011, 3'b000, 10'd0,   10'd0, 631, 236, 0, 0, 0);
      add_vec(0,   1, 3'b011, 3'b000, 10'd0,   10'd0, 631, 236, 0, 1, 0);
      add_vec(0,   1, 3'b011, 3'b000, 10'd0,   10'd0, 316, 236, 1, 0, 0);
      add_vec(0,   1, 3'b011, 3'b000, 10'd0,   10'd0, 316, 236, 0, 0, 0);
      add_vec(0,   1, 3'b011, 3'b000, 10'd0,   10'd0, 319, 236, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_rst)
            do_reset();
         x_vect_in  = vecs[i].xv;
         y_vect_in  = vecs[i].yv;
         paddle_l_y = vecs[i].pl;
         paddle_r_y = vecs[i].pr;
         repeat (vecs[i].n_ticks) tick();
         check_outputs($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                       vecs[i].es, vecs[i].esl, vecs[i].esr);
      end

      // Left-side miss: a -4 serve loads as -3. The ball passes below the paddle and scores for the right player.
      x_vect_in  = 3'b100;
      y_vect_in  = 3'b000;
      paddle_l_y = 10'd0;
      paddle_r_y = 10'd0;
      do_reset();
      repeat (2) tick();
      repeat (105) tick();
      check_outputs("miss.pre", 1, 236, 0, 0, 0);

      // The scoring tick. Keep frame_tick high through SCORED, where it must be ignored.
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      check_outputs("miss.scored", 1, 236, 0, 0, 1);
      x_vect_in = 3'b000;
      y_vect_in = 3'b100;
      @(negedge clk);
      frame_tick = 1'b0;
      check_outputs("miss.back", 316, 236, 1, 0, 0);

      // Counter restarts from zero: two fresh ticks are needed. Vector 0/-4 loads as +1/-3.
      tick();
      check_outputs("reserve.t1", 316, 236, 1, 0, 0);
      tick();
      check_outputs("reserve.t2", 316, 236, 0, 0, 0);
      tick();
      check_outputs("reserve.m1", 317, 233, 0, 0, 0);

      // Top-wall bounce with vy=-3.
      repeat (77) tick();
      check_outputs("top.pre", 394, 2, 0, 0, 0);
      tick();
      check_outputs("top.hit", 395, 0, 0, 0, 0);
      tick();
      check_outputs("top.post", 396, 3, 0, 0, 0);

      // Reset in mid-flight: the ball returns to centre and no point is awarded.
      @(negedge clk);
      rst        = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      frame_tick = 1'b0;
      check_outputs("rst.mid", 316, 236, 1, 0, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_outputs($sformatf("rst.after%0d", c), 316, 236, 1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, meaning screen height in pixels.
REQ-003 SHALL have parameter BALL_SIZE, default 8, meaning ball square edge in pixels.
REQ-004 SHALL have parameter PADDLE_H, default 64, meaning paddle height.
REQ-005 SHALL have parameter PADDLE_W, default 8, meaning paddle width.
REQ-006 SHALL have parameter PADDLE_L_X, default 16, meaning left paddle left edge x.
REQ-007 SHALL have parameter PADDLE_R_X, default 616, meaning right paddle left edge x.
REQ-008 SHALL have parameter SERVE_WAIT, default 60, meaning frame ticks spent in SERVE.
REQ-009 SHALL have port clk, input, 1, system clock.
REQ-010 SHALL have port rst, input, 1; reset rst, synchronous, active-high; clock clk.
REQ-011 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-012 SHALL have ports x_vect_in and y_vect_in, input, 3 each, signed two's-complement serve velocity from the upstream vector source.
REQ-013 SHALL have ports paddle_l_y and paddle_r_y, input, 10 each, paddle top-edge y.
REQ-014 SHALL have ports ball_x and ball_y, output, 10 each, registered ball top-left position.
REQ-015 SHALL have ports score_l and score_r, output, 1 each, one-cycle point pulses for the left and right player.
REQ-016 SHALL have port serving, output, 1, high while state is SERVE.

Function
REQ-017 FSM states SHALL be SERVE, MOVE, SCORED; all updates occur on the clk edge after a frame_tick, so outputs have 1-cycle latency.
REQ-018 SERVE SHALL hold the ball at CX=H_RES/2-BALL_SIZE/2, CY=V_RES/2-BALL_SIZE/2 and count frame_ticks; on the SERVE_WAIT-th tick it SHALL latch vx/vy from the inputs and enter MOVE.
REQ-019 On latch, an input of -4 (3'b100) SHALL load as -3; vx input 0 SHALL load as +1; vy 0 is legal.
REQ-020 MOVE, per frame_tick: nx=ball_x+vx, ny=ball_y+vy, computed at 11-bit signed width with sign-extended velocity.
REQ-021 Top wall: ny<0 SHALL set ball_y=0 and vy=-vy; bottom: ny>V_RES-BALL_SIZE SHALL set ball_y=V_RES-BALL_SIZE and vy=-vy.
REQ-022 Left paddle hit: vx<0, nx<=PADDLE_L_X+PADDLE_W, ball_x>=PADDLE_L_X+PADDLE_W, and ball_y+BALL_SIZE>paddle_l_y and ball_y<paddle_l_y+PADDLE_H SHALL set ball_x=PADDLE_L_X+PADDLE_W and vx=-vx.
REQ-023 Right paddle hit SHALL mirror REQ-022: vx>0, nx+BALL_SIZE>=PADDLE_R_X, ball_x+BALL_SIZE<=PADDLE_R_X, same vertical overlap against paddle_r_y; it SHALL set ball_x=PADDLE_R_X-BALL_SIZE.
REQ-024 With no paddle hit, nx<0 SHALL pulse score_r and nx>H_RES-BALL_SIZE SHALL pulse score_l.
REQ-025 On score, position SHALL NOT update and the FSM SHALL enter SCORED.
REQ-026 X and Y bounces in the same tick SHALL both apply; a score SHALL override any y update.
REQ-027 SCORED SHALL last one clk cycle, hold the score pulse during it, then enter SERVE with the ball at center and the counter cleared.
REQ-028 frame_tick SHALL be ignored in SCORED; inputs x/y_vect_in SHALL be sampled only at serve latch.

Reset
REQ-029 rst SHALL force SERVE, ball_x=CX, ball_y=CY, vx=vy=0, serve counter=0, score_l=score_r=0, serving=1; rst asserted mid-MOVE SHALL abandon motion with no score pulse.

Structure
REQ-030 Package pong_pkg SHALL hold the state enum, the signed 3-bit velocity typedef and the default screen/paddle constants.
REQ-031 The serve frame counter SHALL be sub-module serve_timer (count, done pulse, clear).

Verification (SERVE_WAIT=2)
REQ-032 Serve: rst, then 2 ticks with x=3'b010, y=3'b110 -> serving falls, ball (316,236); next tick -> (318,234).
REQ-033 Top bounce: ball_y=1, vy=-3 -> ball_y=0, vy=+3; next tick ball_y=3.
REQ-034 Left paddle: paddle_l_y=200, ball (26,220), vx=-3 -> ball_x=24, vx=+3.
REQ-035 Miss: paddle_l_y=0, ball (2,300), vx=-3 -> score_r high exactly 1 cycle, then serving=1 and ball (316,236).
REQ-036 Zero/-4 serve: x=3'b000, y=3'b100 -> vx=+1, vy=-3.
REQ-037 rst mid-MOVE at ball (100,100) -> next cycle ball (316,236), serving=1, no score pulse.
